// File: rtl/sar_adc_scan_if.sv
// Result stream of the SAR scan controller: data, channel tag,
// end-of-scan flag and a valid/ready handshake.
interface sar_adc_scan_if #(
    parameter int p_bit_cnt = 8,
    parameter int p_ch_w    = 2
);
    logic [p_bit_cnt-1:0] o_res;
    logic [p_ch_w-1:0]    o_res_ch;
    logic                 o_last;
    logic                 o_valid;
    logic                 i_ready;

    modport master (
        output o_res, o_res_ch, o_last, o_valid,
        input  i_ready
    );

    modport slave (
        input  o_res, o_res_ch, o_last, o_valid,
        output i_ready
    );
endinterface

// File: rtl/sar_adc_scan.sv
// Multi-channel SAR ADC scan controller: mux select, settle, binary
// search against an external DAC/comparator, results on a stalling stream.
module sar_adc_scan #(
    parameter int p_bit_cnt  = 8,
    parameter int p_ch_cnt   = 4,
    parameter int p_samp_cyc = 2,
    parameter int p_ch_w     = (p_ch_cnt > 1) ? $clog2(p_ch_cnt) : 1
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_start,
    input  logic                 i_cont,
    input  logic [p_ch_cnt-1:0]  i_ch_mask,
    output logic                 o_busy,
    output logic [p_ch_w-1:0]    o_mux,
    output logic [p_bit_cnt-1:0] o_dac,
    input  logic                 i_cmp,
    sar_adc_scan_if.master       res_if
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SAMP = 2'd1;
    localparam logic [1:0] S_CONV = 2'd2;
    localparam logic [1:0] S_OUT  = 2'd3;

    localparam int sw = (p_samp_cyc > 1) ? $clog2(p_samp_cyc) : 1;
    localparam logic [sw-1:0] samp_last = sw'(p_samp_cyc - 1);
    localparam logic [p_bit_cnt-1:0] msb = {1'b1, {(p_bit_cnt-1){1'b0}}};

    logic [1:0]           state;
    logic [p_ch_cnt-1:0]  mask;
    logic [p_ch_w-1:0]    ch;
    logic [sw-1:0]        samp_cnt;
    logic [p_bit_cnt-1:0] trial;
    logic [p_bit_cnt-1:0] partial;
    logic [p_bit_cnt-1:0] res;
    logic [p_ch_w-1:0]    res_ch;
    logic                 last;

    logic                 nxt_found;
    logic [p_ch_w-1:0]    nxt_ch;

    function automatic logic [p_ch_w-1:0] low_bit(input logic [p_ch_cnt-1:0] m);
        low_bit = '0;
        for (int i = p_ch_cnt - 1; i >= 0; i--)
            if (m[i]) low_bit = p_ch_w'(i);
    endfunction

    // Lowest set bit of the captured mask strictly above the current channel.
    always_comb begin
        nxt_found = 1'b0;
        nxt_ch    = '0;
        for (int i = p_ch_cnt - 1; i >= 0; i--) begin
            if (mask[i] && (i > int'(ch))) begin
                nxt_found = 1'b1;
                nxt_ch    = p_ch_w'(i);
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state    <= S_IDLE;
            mask     <= '0;
            ch       <= '0;
            samp_cnt <= '0;
            trial    <= '0;
            partial  <= '0;
            res      <= '0;
            res_ch   <= '0;
            last     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_start && (|i_ch_mask)) begin
                        mask     <= i_ch_mask;
                        ch       <= low_bit(i_ch_mask);
                        samp_cnt <= '0;
                        state    <= S_SAMP;
                    end
                end
                S_SAMP: begin
                    if (samp_cnt == samp_last) begin
                        trial   <= msb;
                        partial <= '0;
                        state   <= S_CONV;
                    end else begin
                        samp_cnt <= samp_cnt + 1'b1;
                    end
                end
                S_CONV: begin
                    if (i_cmp) partial <= partial | trial;
                    trial <= trial >> 1;
                    if (trial[0]) begin
                        res    <= partial | (i_cmp ? trial : '0);
                        res_ch <= ch;
                        last   <= ~nxt_found;
                        state  <= S_OUT;
                    end
                end
                default: begin
                    if (res_if.i_ready) begin
                        samp_cnt <= '0;
                        if (nxt_found) begin
                            ch    <= nxt_ch;
                            state <= S_SAMP;
                        end else if (i_cont) begin
                            ch    <= low_bit(mask);
                            state <= S_SAMP;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
            endcase
        end
    end

    assign o_busy          = (state != S_IDLE);
    assign o_mux           = ch;
    assign o_dac           = (state == S_CONV) ? (partial | trial) : '0;
    assign res_if.o_valid  = (state == S_OUT);
    assign res_if.o_res    = res;
    assign res_if.o_res_ch = res_ch;
    assign res_if.o_last   = last;
endmodule

// File: tb/tb_sar_adc_scan.sv
// Directed bench for sar_adc_scan with an ideal comparator model
// driven by a per-channel input code table.
module tb_sar_adc_scan;
    logic       i_clk = 1'b0;
    logic       i_reset = 1'b1;
    logic       i_start = 1'b0;
    logic       i_cont = 1'b0;
    logic [3:0] i_ch_mask = '0;
    logic       o_busy;
    logic [1:0] o_mux;
    logic [7:0] o_dac;
    logic       i_cmp;

    logic [7:0] vin [4];
    logic [7:0] dac_log [$];
    int         checks = 0;
    int         errors = 0;
    int         cyc;
    bit         ok;
    logic       busy1;
    logic [1:0] mux1;

    sar_adc_scan_if #(.p_bit_cnt(8), .p_ch_w(2)) rif ();

    sar_adc_scan dut (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_start   (i_start),
        .i_cont    (i_cont),
        .i_ch_mask (i_ch_mask),
        .o_busy    (o_busy),
        .o_mux     (o_mux),
        .o_dac     (o_dac),
        .i_cmp     (i_cmp),
        .res_if    (rif)
    );

    always #5 i_clk = ~i_clk;

    always_comb i_cmp = (vin[o_mux] >= o_dac);

    // Wait (bounded) for o_valid; cyc counts rising edges taken.
    task automatic wait_valid();
        cyc = 0;
        ok  = 1'b0;
        for (int j = 0; j < 60 && !ok; j++) begin
            @(posedge i_clk);
            cyc++;
            @(negedge i_clk);
            i_start = 1'b0;
            if (cyc == 1) begin
                busy1 = o_busy;
                mux1  = o_mux;
            end
            if (o_dac != 8'h00) dac_log.push_back(o_dac);
            if (rif.o_valid) ok = 1'b1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL valid_timeout: no o_valid within %0d cycles", cyc);
        end
    endtask

    task automatic test_reset();
        @(negedge i_clk);
        checks++;
        if ({o_busy, rif.o_valid, rif.o_last} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: got %b want 000",
                     {o_busy, rif.o_valid, rif.o_last});
        end
        checks++;
        if ({rif.o_res, rif.o_res_ch, o_mux, o_dac} !== 20'h0) begin
            errors++;
            $display("FAIL reset_data: got %h want 0",
                     {rif.o_res, rif.o_res_ch, o_mux, o_dac});
        end
        i_reset = 1'b0;
        @(negedge i_clk);
    endtask

    task automatic test_single();
        vin[0] = 8'hA5;
        i_ch_mask = 4'b0001;
        i_start = 1'b1;
        wait_valid();
        checks++;
        if (busy1 !== 1'b1 || mux1 !== 2'd0) begin
            errors++;
            $display("FAIL single_first: busy=%b mux=%0d want 1/0", busy1, mux1);
        end
        checks++;
        if (cyc != 11) begin
            errors++;
            $display("FAIL single_latency: got %0d want 11", cyc);
        end
        checks++;
        if ({rif.o_res, rif.o_res_ch, rif.o_last} !== {8'hA5, 2'd0, 1'b1}) begin
            errors++;
            $display("FAIL single_res: got %h/%0d/%b want a5/0/1",
                     rif.o_res, rif.o_res_ch, rif.o_last);
        end
        @(negedge i_clk);
        checks++;
        if (rif.o_valid !== 1'b0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL single_idle: valid=%b busy=%b want 0/0",
                     rif.o_valid, o_busy);
        end
    endtask

    task automatic test_scan_gaps();
        logic [7:0] e;
        vin[1] = 8'h00;
        vin[3] = 8'hFF;
        i_ch_mask = 4'b1010;
        dac_log.delete();
        i_start = 1'b1;
        wait_valid();
        checks++;
        if (dac_log.size() != 8) begin
            errors++;
            $display("FAIL gaps_dac_len: got %0d want 8", dac_log.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                e = 8'h80 >> i;
                checks++;
                if (dac_log[i] !== e) begin
                    errors++;
                    $display("FAIL gaps_dac[%0d]: got %h want %h", i, dac_log[i], e);
                end
            end
        end
        checks++;
        if ({rif.o_res, rif.o_res_ch, rif.o_last} !== {8'h00, 2'd1, 1'b0}) begin
            errors++;
            $display("FAIL gaps_res0: got %h/%0d/%b want 00/1/0",
                     rif.o_res, rif.o_res_ch, rif.o_last);
        end
        wait_valid();
        checks++;
        if (cyc != 11 ||
            {rif.o_res, rif.o_res_ch, rif.o_last} !== {8'hFF, 2'd3, 1'b1}) begin
            errors++;
            $display("FAIL gaps_res1: got %h/%0d/%b cyc %0d want ff/3/1 cyc 11",
                     rif.o_res, rif.o_res_ch, rif.o_last, cyc);
        end
        @(negedge i_clk);
        checks++;
        if (o_busy !== 1'b0) begin
            errors++;
            $display("FAIL gaps_idle: busy=%b want 0", o_busy);
        end
    endtask

    task automatic test_backpressure();
        vin[0] = 8'h3C;
        vin[1] = 8'hC3;
        i_ch_mask = 4'b0011;
        rif.i_ready = 1'b0;
        i_start = 1'b1;
        wait_valid();
        checks++;
        if ({rif.o_res, rif.o_res_ch, rif.o_last} !== {8'h3C, 2'd0, 1'b0}) begin
            errors++;
            $display("FAIL bp_res0: got %h/%0d/%b want 3c/0/0",
                     rif.o_res, rif.o_res_ch, rif.o_last);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge i_clk);
            checks++;
            if ({rif.o_valid, rif.o_res, rif.o_res_ch, rif.o_last, o_mux, o_dac}
                !== {1'b1, 8'h3C, 2'd0, 1'b0, 2'd0, 8'h00}) begin
                errors++;
                $display("FAIL bp_hold[%0d]: valid=%b res=%h ch=%0d mux=%0d dac=%h",
                         i, rif.o_valid, rif.o_res, rif.o_res_ch, o_mux, o_dac);
            end
        end
        rif.i_ready = 1'b1;
        wait_valid();
        checks++;
        if (cyc != 11 ||
            {rif.o_res, rif.o_res_ch, rif.o_last} !== {8'hC3, 2'd1, 1'b1}) begin
            errors++;
            $display("FAIL bp_res1: got %h/%0d/%b cyc %0d want c3/1/1 cyc 11",
                     rif.o_res, rif.o_res_ch, rif.o_last, cyc);
        end
        @(negedge i_clk);
    endtask

    task automatic test_continuous();
        logic [1:0] ech;
        logic [7:0] eres;
        vin[1] = 8'h55;
        vin[2] = 8'hAA;
        i_ch_mask = 4'b0110;
        i_cont = 1'b1;
        i_start = 1'b1;
        for (int r = 0; r < 6; r++) begin
            wait_valid();
            ech  = (r % 2 == 0) ? 2'd1 : 2'd2;
            eres = (r % 2 == 0) ? 8'h55 : 8'hAA;
            checks++;
            if ({rif.o_res, rif.o_res_ch, rif.o_last} !== {eres, ech, ech == 2'd2}) begin
                errors++;
                $display("FAIL cont_res[%0d]: got %h/%0d/%b want %h/%0d/%b", r,
                         rif.o_res, rif.o_res_ch, rif.o_last, eres, ech, ech == 2'd2);
            end
            if (r == 5) i_cont = 1'b0;
        end
        repeat (3) @(negedge i_clk);
        checks++;
        if (o_busy !== 1'b0 || rif.o_valid !== 1'b0) begin
            errors++;
            $display("FAIL cont_end: busy=%b valid=%b want 0/0", o_busy, rif.o_valid);
        end
    endtask

    task automatic test_ignore();
        i_ch_mask = 4'b0000;
        i_start = 1'b1;
        @(negedge i_clk);
        @(negedge i_clk);
        i_start = 1'b0;
        checks++;
        if (o_busy !== 1'b0) begin
            errors++;
            $display("FAIL ign_mask0: busy=%b want 0", o_busy);
        end
        vin[0] = 8'h12;
        vin[2] = 8'h34;
        i_ch_mask = 4'b0101;
        i_start = 1'b1;
        wait_valid();
        checks++;
        if ({rif.o_res, rif.o_res_ch, rif.o_last} !== {8'h12, 2'd0, 1'b0}) begin
            errors++;
            $display("FAIL ign_res0: got %h/%0d/%b want 12/0/0",
                     rif.o_res, rif.o_res_ch, rif.o_last);
        end
        i_start = 1'b1;
        i_ch_mask = 4'b0010;
        wait_valid();
        checks++;
        if (cyc != 11 ||
            {rif.o_res, rif.o_res_ch, rif.o_last} !== {8'h34, 2'd2, 1'b1}) begin
            errors++;
            $display("FAIL ign_res1: got %h/%0d/%b cyc %0d want 34/2/1 cyc 11",
                     rif.o_res, rif.o_res_ch, rif.o_last, cyc);
        end
        @(negedge i_clk);
        checks++;
        if (o_busy !== 1'b0) begin
            errors++;
            $display("FAIL ign_idle: busy=%b want 0", o_busy);
        end
    endtask

    task automatic test_async_reset();
        vin[3] = 8'h5A;
        i_ch_mask = 4'b1000;
        i_start = 1'b1;
        @(posedge i_clk);
        #1 i_start = 1'b0;
        repeat (4) @(posedge i_clk);
        #2 i_reset = 1'b1;
        #1;
        checks++;
        if ({o_busy, rif.o_valid, rif.o_last, rif.o_res, rif.o_res_ch, o_mux, o_dac}
            !== 23'h0) begin
            errors++;
            $display("FAIL areset_out: busy=%b mux=%0d dac=%h res=%h want all 0",
                     o_busy, o_mux, o_dac, rif.o_res);
        end
        @(negedge i_clk);
        i_reset = 1'b0;
        @(negedge i_clk);
        i_start = 1'b1;
        wait_valid();
        checks++;
        if (cyc != 11 ||
            {rif.o_res, rif.o_res_ch, rif.o_last} !== {8'h5A, 2'd3, 1'b1}) begin
            errors++;
            $display("FAIL areset_res: got %h/%0d/%b cyc %0d want 5a/3/1 cyc 11",
                     rif.o_res, rif.o_res_ch, rif.o_last, cyc);
        end
        @(negedge i_clk);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) vin[i] = 8'h00;
        rif.i_ready = 1'b1;
        test_reset();
        test_single();
        test_scan_gaps();
        test_backpressure();
        test_continuous();
        test_ignore();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
